// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep self-test stage.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int G_NOT     = 0;
  localparam int G_AND     = 1;
  localparam int G_OR      = 2;
  localparam int G_NAND    = 3;
  localparam int G_NOR     = 4;
  localparam int G_XOR     = 5;
  localparam int G_XNOR    = 6;
  localparam int NUM_GATES = 7;
  localparam int NUM_VEC   = 4;

endpackage

// File: rtl/gate_sweep_golden.sv
// Combinational truth table of the 7-output two-input gate block.
module gate_sweep_golden
  import gate_sweep_pkg::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_GATES-1:0] exp_o
);

  always_comb begin
    exp_o         = '0;
    exp_o[G_NOT]  = ~a_i;
    exp_o[G_AND]  = a_i & b_i;
    exp_o[G_OR]   = a_i | b_i;
    exp_o[G_NAND] = ~(a_i & b_i);
    exp_o[G_NOR]  = ~(a_i | b_i);
    exp_o[G_XOR]  = a_i ^ b_i;
    exp_o[G_XNOR] = ~(a_i ^ b_i);
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps a/b through all four vectors, compares the gate block outputs with
// the golden table and reports pass/fail. GATE_SWEEP_LOOP_EN adds back-to-back looping.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef GATE_SWEEP_LOOP_EN
  input  logic                 loop,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 a_o,
  output logic                 b_o,
  input  logic [NUM_GATES-1:0] c_i,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask,
  output logic [1:0]           first_err_vec,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int             SW          = CNT_W + 3;
  localparam logic [SW-1:0]  CNT_MAX     = SW'((1 << CNT_W) - 1);
  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0]     VEC_LAST    = 2'(NUM_VEC - 1);

  state_e               state_q, state_d;
  logic [1:0]           vec_q, vec_d;
  logic [3:0]           settle_q, settle_d;
  logic                 a_q, a_d, b_q, b_d;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [NUM_GATES-1:0] fm_q, fm_d;
  logic [1:0]           fev_q, fev_d;
  logic [CNT_W-1:0]     ec_q, ec_d;

  logic [NUM_GATES-1:0] exp_w, mism_w;
  logic [SW-1:0]        sum_w;

  gate_sweep_golden u_golden (
    .a_i   (vec_q[1]),
    .b_i   (vec_q[0]),
    .exp_o (exp_w)
  );

  assign mism_w = c_i ^ exp_w;
  assign sum_w  = SW'(ec_q) + SW'($countones(mism_w));

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    fm_d     = fm_q;
    fev_d    = fev_q;
    ec_d     = ec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SETTLE;
          vec_d    = '0;
          a_d      = 1'b0;
          b_d      = 1'b0;
          settle_d = '0;
          fm_d     = '0;
          ec_d     = '0;
          fev_d    = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
        else                         settle_d = settle_q + 4'd1;
      end
      S_SAMPLE: begin
        fm_d = fm_q | mism_w;
        ec_d = (sum_w > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_w[CNT_W-1:0];
        // fail_mask still empty means this is the first mismatching vector
        if (mism_w != '0 && fm_q == '0) fev_d = vec_q;
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fm_d == '0);
        end else begin
          vec_d    = vec_q + 2'd1;
          a_d      = vec_d[1];
          b_d      = vec_d[0];
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef GATE_SWEEP_LOOP_EN
        // Results are kept so they accumulate across looped sweeps
        if (loop) begin
          state_d  = S_SETTLE;
          vec_d    = '0;
          a_d      = 1'b0;
          b_d      = 1'b0;
          settle_d = '0;
          busy_d   = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fm_q     <= '0;
      fev_q    <= '0;
      ec_q     <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fm_q     <= fm_d;
      fev_q    <= fev_d;
      ec_q     <= ec_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign a_o           = a_q;
  assign b_o           = b_q;
  assign pass          = pass_q;
  assign fail_mask     = fm_q;
  assign first_err_vec = fev_q;
  assign err_cnt       = ec_q;

endmodule
